// File: rtl/fifo_drain_pkg.sv
// Shared definitions for the 128-bit FIFO drain: FSM encoding, FIFO word width
// and the beat-count / beat-index-width helper.
package fifo_drain_pkg;

    localparam int FIFO_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOAD = 2'd2,
        SEND = 2'd3
    } state_e;

    typedef struct packed {
        logic [7:0] beats;
        logic [7:0] idx_w;
    } beat_cfg_t;

    function automatic bit legal_width(int out_width);
        return (out_width == 8) || (out_width == 16) || (out_width == 32) ||
               (out_width == 64) || (out_width == 128);
    endfunction

    // Beat index is never narrower than one bit, even when a word is a single beat.
    function automatic beat_cfg_t beat_cfg(int out_width);
        beat_cfg_t cfg;
        int        beats;
        beats     = (out_width > 0) ? FIFO_W / out_width : 1;
        cfg.beats = 8'(beats);
        cfg.idx_w = 8'((beats > 1) ? $clog2(beats) : 1);
        return cfg;
    endfunction

endpackage

// File: rtl/word_slice_mux.sv
// Combinational selector of beat idx out of a 128-bit word, either MSB-first
// or LSB-first.
module word_slice_mux
    import fifo_drain_pkg::*;
#(
    parameter int OUT_WIDTH = 32,
    parameter bit FIRST_MSB = 1'b1,
    parameter int IDX_W     = 2
) (
    input  logic [FIFO_W-1:0]    word,
    input  logic [IDX_W-1:0]     idx,
    output logic [OUT_WIDTH-1:0] slice
);

    localparam int BEATS = FIFO_W / OUT_WIDTH;

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        slice = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (idx == IDX_W'(k)) begin
                slice = FIRST_MSB ? word[FIFO_W-1-k*OUT_WIDTH -: OUT_WIDTH]
                                  : word[k*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

endmodule

// File: rtl/fifo128_drain.sv
// Sole reader of the 128-bit generator FIFO: pops one word at a time and
// serializes it into OUT_WIDTH-bit beats on a valid/ready stream.
module fifo128_drain
    import fifo_drain_pkg::*;
#(
    parameter int OUT_WIDTH = 32,
    parameter int FIRST_MSB = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    output logic                 fifo_rd,
    input  logic [FIFO_W-1:0]    fifo_data,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic [CNT_W-1:0]     word_count
);

    localparam beat_cfg_t CFG   = beat_cfg(OUT_WIDTH);
    localparam int        BEATS = int'(CFG.beats);
    localparam int        IDX_W = int'(CFG.idx_w);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    if (!legal_width(OUT_WIDTH)) begin : g_bad_width
        $error("fifo128_drain: OUT_WIDTH must be 8, 16, 32, 64 or 128");
    end

    state_e             state_q,     state_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [FIFO_W-1:0]  hold_q,      hold_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               fifo_rd_q,   fifo_rd_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q,  out_last_d;
    logic               busy_q,      busy_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (!fifo_empty) state_d = REQ;
            REQ:  state_d = LOAD;
            LOAD: begin
                hold_d  = fifo_data;
                idx_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                // fifo_empty is only consulted on the final-beat handshake.
                if (out_valid_q && out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = fifo_empty ? IDLE : REQ;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of what the next state implies.
        fifo_rd_d   = (state_d == REQ);
        out_valid_d = (state_d == SEND);
        out_last_d  = (state_d == SEND) && (idx_d == LAST_IDX);
        busy_d      = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            fifo_rd_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            fifo_rd_q   <= fifo_rd_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    word_slice_mux #(
        .OUT_WIDTH (OUT_WIDTH),
        .FIRST_MSB (FIRST_MSB != 0),
        .IDX_W     (IDX_W)
    ) u_slice (
        .word  (hold_q),
        .idx   (idx_q),
        .slice (out_data)
    );

    assign fifo_rd    = fifo_rd_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_fifo128_drain.sv
// Bench for fifo128_drain: a W=32 MSB-first instance and a W=8 LSB-first instance,
// each fed by a queue-based FIFO model and checked against an arithmetic beat model.
module tb_fifo128_drain;

    logic         clk = 1'b0;
    logic         rst;
    logic         ready0, ready1;
    logic         empty0 = 1'b1, empty1 = 1'b1;
    logic [127:0] fdata0 = '0, fdata1 = '0;

    logic         rd0, v0, l0, b0;
    logic [31:0]  d0;
    logic [15:0]  wc0;
    logic         rd1, v1, l1, b1;
    logic [7:0]   d1;
    logic [15:0]  wc1;

    logic [127:0] fq0[$], fq1[$];
    logic [128:0] obs0[$], obs1[$], exp0[$], exp1[$];
    int           wc_exp0 = 0, wc_exp1 = 0;
    int           underflow = 0, proto0 = 0, proto1 = 0;
    int           checks = 0, errors = 0;

    localparam logic [127:0] W0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    always #5 clk = ~clk;

    fifo128_drain #(.OUT_WIDTH(32), .FIRST_MSB(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .fifo_empty(empty0), .fifo_rd(rd0), .fifo_data(fdata0),
        .out_data(d0), .out_valid(v0), .out_ready(ready0), .out_last(l0),
        .busy(b0), .word_count(wc0));

    fifo128_drain #(.OUT_WIDTH(8), .FIRST_MSB(0), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .fifo_empty(empty1), .fifo_rd(rd1), .fifo_data(fdata1),
        .out_data(d1), .out_valid(v1), .out_ready(ready1), .out_last(l1),
        .busy(b1), .word_count(wc1));

    // FIFO models: registered read data, no underflow protection (pop on empty is counted).
    always @(posedge clk) begin
        if (rd0) begin
            if (fq0.size() == 0) underflow++;
            else fdata0 <= fq0.pop_front();
        end
        if (rd1) begin
            if (fq1.size() == 0) underflow++;
            else fdata1 <= fq1.pop_front();
        end
    end

    always @(negedge clk) begin
        empty0 <= (fq0.size() == 0);
        empty1 <= (fq1.size() == 0);
    end

    // Stream monitors: record handshakes, flag stall-stability and pop-strobe violations.
    logic        pv0 = 0, pr0 = 0, pl0 = 0, prd0 = 0;
    logic [31:0] pd0 = '0;
    always @(negedge clk) begin
        if (rst) begin
            pv0 <= 1'b0; prd0 <= 1'b0;
        end else begin
            if (pv0 && !pr0 && (!v0 || d0 != pd0 || l0 != pl0)) proto0++;
            if (prd0 && rd0) proto0++;
            if (v0 && ready0) obs0.push_back({l0, 96'd0, d0});
            pv0 <= v0; pr0 <= ready0; pd0 <= d0; pl0 <= l0; prd0 <= rd0;
        end
    end

    logic       pv1 = 0, pr1 = 0, pl1 = 0, prd1 = 0;
    logic [7:0] pd1 = '0;
    always @(negedge clk) begin
        if (rst) begin
            pv1 <= 1'b0; prd1 <= 1'b0;
        end else begin
            if (pv1 && !pr1 && (!v1 || d1 != pd1 || l1 != pl1)) proto1++;
            if (prd1 && rd1) proto1++;
            if (v1 && ready1) obs1.push_back({l1, 120'd0, d1});
            pv1 <= v1; pr1 <= ready1; pd1 <= d1; pl1 <= l1; prd1 <= rd1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference beat k of a word: shift the word so the wanted slice lands at bit 0.
    function automatic logic [127:0] exp_beat(logic [127:0] w, int k, int width, bit msb);
        logic [127:0] mask;
        int           sh;
        mask = (width == 128) ? {128{1'b1}} : ((128'd1 << width) - 128'd1);
        sh   = msb ? 128 - (k + 1) * width : k * width;
        return (w >> sh) & mask;
    endfunction

    task automatic push_word(input int which, input logic [127:0] w);
        int width;
        bit msb;
        int beats;
        width = (which == 0) ? 32 : 8;
        msb   = (which == 0);
        beats = 128 / width;
        for (int k = 0; k < beats; k++) begin
            if (which == 0) exp0.push_back({k == beats - 1, exp_beat(w, k, width, msb)});
            else            exp1.push_back({k == beats - 1, exp_beat(w, k, width, msb)});
        end
        if (which == 0) begin fq0.push_back(w); wc_exp0++; end
        else            begin fq1.push_back(w); wc_exp1++; end
    endtask

    task automatic compare_sb(input int which, input string tag);
        logic [128:0] o[$], e[$];
        if (which == 0) begin o = obs0; e = exp0; obs0.delete(); exp0.delete(); end
        else            begin o = obs1; e = exp1; obs1.delete(); exp1.delete(); end
        check({tag, " beat count"}, 129'(o.size()), 129'(e.size()));
        for (int i = 0; i < o.size() && i < e.size(); i++) check(tag, o[i], e[i]);
    endtask

    task automatic wait_idle(input int which, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (which == 0) done = (b0 == 1'b0) && (fq0.size() == 0);
            else            done = (b1 == 1'b0) && (fq1.size() == 0);
        end
        if (!done) check("idle timeout", 129'd0, 129'd1);
    endtask

    initial begin
        int  t_first1, t_last1, t_first2, rd_after, lasts, last_pos;
        bit  any_rd, any_busy, any_valid;

        rst = 1'b1; ready0 = 1'b0; ready1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outs dut0", {rd0, v0, l0, b0, d0, wc0}, '0);
        check("reset outs dut1", {rd1, v1, l1, b1, d1, wc1}, '0);
        rst = 1'b0;
        tick(); tick();

        // Single word, exact cycle timing.
        ready0 = 1'b1;
        push_word(0, W0);
        for (int c = 1; c <= 7; c++) begin
            tick();
            check($sformatf("single rd c%0d", c), rd0, (c == 1));
            check($sformatf("single valid c%0d", c), v0, (c >= 3 && c <= 6));
            check($sformatf("single last c%0d", c), l0, (c == 6));
            if (c >= 3 && c <= 6) check($sformatf("single data c%0d", c), d0, exp_beat(W0, c - 3, 32, 1));
        end
        check("single busy", b0, 1'b0);
        check("single count", wc0, 16'd1);
        check("single beat0 const", exp0[0], {1'b0, 128'h00112233});
        compare_sb(0, "single sb");

        // Backpressure during beat 1.
        push_word(0, W0);
        repeat (4) tick();
        ready0 = 1'b0;
        for (int c = 4; c <= 7; c++) begin
            check($sformatf("bp hold c%0d", c), {rd0, v0, d0}, {1'b0, 1'b1, 32'h44556677});
            if (c < 7) tick();
        end
        ready0 = 1'b1;
        wait_idle(0, 50);
        check("bp count", wc0, 16'(wc_exp0));
        compare_sb(0, "bp sb");

        // Empty guard.
        any_rd = 0; any_busy = 0; any_valid = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            any_rd    |= rd0 | rd1;
            any_busy  |= b0 | b1;
            any_valid |= v0 | v1;
        end
        check("guard rd", any_rd, 1'b0);
        check("guard busy", any_busy, 1'b0);
        check("guard valid", any_valid, 1'b0);

        // Back-to-back words.
        push_word(0, W0);
        push_word(0, {$urandom, $urandom, $urandom, $urandom});
        t_first1 = -1; t_last1 = -1; t_first2 = -1; rd_after = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (v0 && t_first1 < 0) t_first1 = c;
            if (t_last1 >= 0 && c == t_last1 + 1) rd_after = rd0;
            if (t_last1 >= 0 && c > t_last1 && v0 && t_first2 < 0) t_first2 = c;
            if (v0 && l0 && t_last1 < 0) t_last1 = c;
        end
        check("b2b first beat", 129'(t_first1), 129'd3);
        check("b2b req after last", 129'(rd_after), 129'd1);
        check("b2b spacing", 129'(t_first2 - t_first1), 129'd6);
        wait_idle(0, 50);
        check("b2b count", wc0, 16'(wc_exp0));
        compare_sb(0, "b2b sb");

        // W=8, LSB-first.
        ready1 = 1'b1;
        push_word(1, W0);
        wait_idle(1, 60);
        check("w8 beats", 129'(obs1.size()), 129'd16);
        if (obs1.size() == 16) begin
            check("w8 first", obs1[0], {1'b0, 128'hFF});
            check("w8 final", obs1[15], {1'b1, 128'h00});
            lasts = 0; last_pos = -1;
            for (int i = 0; i < 16; i++) if (obs1[i][128]) begin lasts++; last_pos = i; end
            check("w8 last once", 129'(lasts), 129'd1);
            check("w8 last pos", 129'(last_pos), 129'd15);
        end
        check("w8 count", wc1, 16'(wc_exp1));
        compare_sb(1, "w8 sb");

        // Randomized traffic on both instances.
        for (int c = 0; c < 1500; c++) begin
            ready0 = ($urandom_range(9) < 7);
            ready1 = ($urandom_range(9) < 7);
            if ($urandom_range(11) == 0) push_word(0, {$urandom, $urandom, $urandom, $urandom});
            if ($urandom_range(31) == 0) push_word(1, {$urandom, $urandom, $urandom, $urandom});
            tick();
        end
        ready0 = 1'b1; ready1 = 1'b1;
        wait_idle(0, 3000);
        wait_idle(1, 3000);
        check("rand count dut0", wc0, 16'(wc_exp0));
        check("rand count dut1", wc1, 16'(wc_exp1));
        compare_sb(0, "rand sb dut0");
        compare_sb(1, "rand sb dut1");

        // Reset in the middle of beat 2.
        push_word(0, W0);
        repeat (5) tick();
        check("mid beat2", {v0, d0}, {1'b1, 32'h8899AABB});
        #2 rst = 1'b1;
        #1;
        check("mid async clear dut0", {rd0, v0, l0, b0, d0, wc0}, '0);
        check("mid async clear dut1", {rd1, v1, l1, b1, d1, wc1}, '0);
        tick(); tick();
        rst = 1'b0;
        obs0.delete(); exp0.delete(); obs1.delete(); exp1.delete();
        wc_exp0 = 0; wc_exp1 = 0;
        any_rd = 0; any_busy = 0; any_valid = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            any_rd    |= rd0;
            any_busy  |= b0;
            any_valid |= v0;
        end
        check("post reset idle", {any_rd, any_busy, any_valid}, '0);
        check("post reset count", wc0, 16'd0);

        check("fifo underflow", 129'(underflow), 129'd0);
        check("stream protocol dut0", 129'(proto0), 129'd0);
        check("stream protocol dut1", 129'(proto1), 129'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
